key_cmd_decoder: RTL and testbench
==================================

Name: key_cmd_decoder

Overview:
- Converts the PS/2 set-2 scan-code byte stream from the keyboard receiver into the single-cycle cmd_valid/cmd_id/x_in/y_in command stream consumed by the drawing engine.
- Handles E0 (extended) and F0 (break) prefixes, held-key repeat filtering, and a two-hex-digit palette-coordinate entry sequence.
- Sits between the PS/2 byte receiver and the drawing engine in the hid path.

Parameters:
- PREFIX_TIMEOUT, 1_000_000, clock cycles allowed between a prefix byte and its code byte before the prefix is discarded.
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low (asserted when 0)
- scan_valid  in  1  one-cycle strobe, scan_code valid
- scan_code  in  8  received PS/2 byte
- cmd_valid  out  1  one-cycle command strobe
- cmd_id  out  4  command code
- x_in  out  7  palette x for PALETTE_MOVE, {3'b0,hex}
- y_in  out  7  palette y for PALETTE_MOVE, {3'b0,hex}
- entry_active  out  1  high while a palette-coordinate entry is in progress

Behaviour:
- Reset (reset==0, asynchronous): cmd_valid=0, cmd_id=0 (NONE), x_in=0, y_in=0, entry_active=0, prefix FSM=IDLE, entry FSM=E_IDLE, held=none, timeout counter=0.
- Command codes: NONE 0, UP 1, DOWN 2, LEFT 3, RIGHT 4, ENTER 5, COLOR 6, PALETTE_MOVE 7, PALETTE_SEL 8, RETURN_DRAW 9.
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 then F0).
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a make code (non-extended), and the FSM stays in IDLE.
  - EXT: F0 goes to EXT_BRK; any other byte is an extended make code, then IDLE.
  - BRK and EXT_BRK: the next byte is a break code, then IDLE.
  - A repeated E0 in EXT stays in EXT. An F0 in BRK stays in BRK.
- Timeout: the counter clears on every scan_valid. It counts while the FSM is not in IDLE. When it reaches PREFIX_TIMEOUT, the FSM returns to IDLE, no command is issued, and the counter clears.
- Held filter: held = {ext, code} of the last make code, cleared by a break code whose {ext,code} matches.
  - A make code equal to held is a typematic repeat.
  - Repeats of arrow codes pass through; repeats of every other code are dropped.
  - A non-matching break code leaves held unchanged.
- Make-code map in E_IDLE:
  - E0 75 = UP, E0 72 = DOWN, E0 6B = LEFT, E0 74 = RIGHT.
  - 5A (non-ext) and E0 5A (keypad) = ENTER.
  - 21 ('C') = COLOR, 29 (space) = PALETTE_SEL, 76 (Esc) = RETURN_DRAW.
  - 4D ('P') starts entry: go to E_X; no command issued.
  - All other codes are ignored.
- Entry FSM: E_IDLE, E_X, E_Y. entry_active=1 in E_X and E_Y.
  - Hex keys: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9, 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
  - In E_X, a hex key latches x_hold and goes to E_Y.
  - In E_Y, a hex key issues PALETTE_MOVE with x_in={3'b0,x_hold} and y_in={3'b0,digit}, then goes to E_IDLE.
  - 76 (Esc) in E_X or E_Y aborts to E_IDLE with no command.
  - Any other key in E_X or E_Y is ignored; arrows are not forwarded while entry is active.
  - 21 is a hex digit during entry, not COLOR.
- Output timing: cmd_valid rises exactly 1 cycle after the scan_valid that carries the final code byte, and is high for 1 cycle.
  - cmd_id, x_in and y_in update in the same cycle as cmd_valid and hold afterwards.
  - x_in and y_in change only on PALETTE_MOVE.
- At most one command is issued per scan_valid. Back-to-back scan_valid on consecutive cycles is supported, giving consecutive cmd_valid pulses.
- Break codes never issue commands.
- Reset mid-sequence: all FSMs return to IDLE / E_IDLE immediately; partial prefixes and entry are lost.

Decomposition:
- hid_cmd_pkg holds:
  - the CMD_* localparams shared with the drawing engine;
  - the scan-code constants (SC_E0, SC_F0, SC_UP, …);
  - a hex-key lookup function returning {valid, nibble}.
- One natural sub-module, ps2_prefix_fsm: it owns the prefix states and the timeout, and outputs code_valid, code, is_ext, is_break. The top level holds the held filter, the entry FSM and the output registers.

Test Plan:
- Bytes E0 75 -> one cmd_valid with cmd_id=1, one cycle after the 75 strobe. Then E0 F0 75 -> no command, and held is cleared.
- Bytes 5A 5A 5A F0 5A 5A -> exactly two ENTER pulses (first make, and the make after the break). Bytes E0 74 repeated 3 times -> three RIGHT pulses.
- Bytes 4D 2B 1E -> entry_active high after 4D. Then PALETTE_MOVE with x_in=7'h0F, y_in=7'h02. entry_active is low after 1E.
- Bytes 4D 21 76 -> no command; entry aborted. Then 21 -> COLOR (cmd_id=6).
- Byte E0, then idle for PREFIX_TIMEOUT cycles (PREFIX_TIMEOUT=16 in the bench), then 75 -> no command. The FSM is back in IDLE and a following E0 75 gives UP.
- Assert reset=0 after E0 F0 mid-sequence, then release it -> all outputs are at their reset values. Byte 74 alone -> no command; E0 74 -> RIGHT.

Source files
------------

// File: rtl/hid_cmd_pkg.sv
// Shared definitions for the keyboard command path.
//   - CMD_* command codes understood by the drawing engine
//   - PS/2 set-2 scan-code constants used by the decoder
//   - prefix / entry state encodings
//   - hex_lookup(): maps a scan code to {valid, nibble}
package hid_cmd_pkg;

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] CMD_UP           = 4'd1;
  localparam logic [3:0] CMD_DOWN         = 4'd2;
  localparam logic [3:0] CMD_LEFT         = 4'd3;
  localparam logic [3:0] CMD_RIGHT        = 4'd4;
  localparam logic [3:0] CMD_ENTER        = 4'd5;
  localparam logic [3:0] CMD_COLOR        = 4'd6;
  localparam logic [3:0] CMD_PALETTE_MOVE = 4'd7;
  localparam logic [3:0] CMD_PALETTE_SEL  = 4'd8;
  localparam logic [3:0] CMD_RETURN_DRAW  = 4'd9;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_P     = 8'h4D;

  typedef enum logic [1:0] {
    P_IDLE,
    P_EXT,
    P_BRK,
    P_EXT_BRK
  } prefix_state_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_X,
    E_Y
  } entry_state_t;

  // Returns {1'b1, nibble} for a hex-digit key, 5'h00 otherwise.
  function automatic logic [4:0] hex_lookup(input logic [7:0] sc);
    logic [4:0] r;
    case (sc)
      8'h45:   r = 5'h10;
      8'h16:   r = 5'h11;
      8'h1E:   r = 5'h12;
      8'h26:   r = 5'h13;
      8'h25:   r = 5'h14;
      8'h2E:   r = 5'h15;
      8'h36:   r = 5'h16;
      8'h3D:   r = 5'h17;
      8'h3E:   r = 5'h18;
      8'h46:   r = 5'h19;
      8'h1C:   r = 5'h1A;
      8'h32:   r = 5'h1B;
      8'h21:   r = 5'h1C;
      8'h23:   r = 5'h1D;
      8'h24:   r = 5'h1E;
      8'h2B:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_cmd_decoder_if.sv
// Byte-in / command-out bundle of the keyboard command decoder.
//   scan_valid, scan_code : PS/2 byte strobe from the receiver
//   cmd_valid, cmd_id     : one-cycle command strobe and code
//   x_in, y_in            : palette coordinates for PALETTE_MOVE
//   entry_active          : palette-coordinate entry in progress
// slave  = the decoder, master = the byte source / command sink.
interface key_cmd_decoder_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       cmd_valid;
  logic [3:0] cmd_id;
  logic [6:0] x_in;
  logic [6:0] y_in;
  logic       entry_active;

  modport slave (
    input  scan_valid, scan_code,
    output cmd_valid, cmd_id, x_in, y_in, entry_active
  );

  modport master (
    output scan_valid, scan_code,
    input  cmd_valid, cmd_id, x_in, y_in, entry_active
  );
endinterface

// File: rtl/ps2_prefix_fsm.sv
// Strips E0 / F0 prefixes from the PS/2 byte stream.
//   clk, reset            : clock, asynchronous active-low reset
//   scan_valid, scan_code : incoming byte strobe
//   code_valid            : combinational strobe, a final code byte arrived
//   code, is_ext, is_break: that byte and its accumulated prefix flags
// A pending prefix is dropped after PREFIX_TIMEOUT idle cycles.
module ps2_prefix_fsm
  import hid_cmd_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_ext,
  output logic       is_break
);

  prefix_state_t   state_reg, state_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            to_hit;

  assign code   = scan_code;
  assign to_hit = (to_cnt_reg == TO_W'(PREFIX_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= P_IDLE;
      to_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    code_valid  = 1'b0;
    is_ext      = 1'b0;
    is_break    = 1'b0;
    to_cnt_next = '0;
    if (scan_valid) begin
      case (state_reg)
        P_IDLE: begin
          if (scan_code == SC_E0)      state_next = P_EXT;
          else if (scan_code == SC_F0) state_next = P_BRK;
          else                         code_valid = 1'b1;
        end
        P_EXT: begin
          if (scan_code == SC_F0) begin
            state_next = P_EXT_BRK;
          end else if (scan_code != SC_E0) begin
            code_valid = 1'b1;
            is_ext     = 1'b1;
            state_next = P_IDLE;
          end
        end
        P_BRK: begin
          if (scan_code != SC_F0) begin
            code_valid = 1'b1;
            is_break   = 1'b1;
            state_next = P_IDLE;
          end
        end
        P_EXT_BRK: begin
          code_valid = 1'b1;
          is_ext     = 1'b1;
          is_break   = 1'b1;
          state_next = P_IDLE;
        end
        default: state_next = P_IDLE;
      endcase
    end else if (state_reg != P_IDLE) begin
      // Idle while a prefix is pending: count, and give up at the limit.
      if (to_hit) state_next = P_IDLE;
      else        to_cnt_next = to_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/key_cmd_decoder.sv
// Keyboard command decoder: PS/2 set-2 bytes in, drawing commands out.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : key_cmd_decoder_if.slave (scan byte in, command out)
// Prefix handling lives in ps2_prefix_fsm; this level filters typematic
// repeats, runs the palette-coordinate entry FSM and registers outputs,
// so a command appears one cycle after its final code byte.
module key_cmd_decoder
  import hid_cmd_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  key_cmd_decoder_if.slave   bus
);

  logic       code_valid;
  logic [7:0] code;
  logic       is_ext;
  logic       is_break;

  ps2_prefix_fsm #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT),
    .TO_W          (TO_W)
  ) u_prefix (
    .clk       (clk),
    .reset     (reset),
    .scan_valid(bus.scan_valid),
    .scan_code (bus.scan_code),
    .code_valid(code_valid),
    .code      (code),
    .is_ext    (is_ext),
    .is_break  (is_break)
  );

  // held key as {ext, code}
  logic         held_valid_reg, held_valid_next;
  logic [8:0]   held_key_reg, held_key_next;
  entry_state_t entry_reg, entry_next;
  logic [3:0]   x_hold_reg, x_hold_next;

  logic         cmd_valid_reg;
  logic [3:0]   cmd_id_reg;
  logic [6:0]   x_reg, y_reg;

  logic [8:0]   key;
  logic [4:0]   hex_res;
  logic         hex_ok, esc_key, is_arrow, repeat_hit;
  logic         fire, fire_move;
  logic [3:0]   fire_id;

  assign key        = {is_ext, code};
  assign hex_res    = hex_lookup(code);
  assign hex_ok     = hex_res[4] & ~is_ext;
  assign esc_key    = ~is_ext & (code == SC_ESC);
  assign is_arrow   = is_ext & ((code == SC_UP) | (code == SC_DOWN) |
                                (code == SC_LEFT) | (code == SC_RIGHT));
  assign repeat_hit = held_valid_reg & (held_key_reg == key);

  always_comb begin
    held_valid_next = held_valid_reg;
    held_key_next   = held_key_reg;
    entry_next      = entry_reg;
    x_hold_next     = x_hold_reg;
    fire            = 1'b0;
    fire_move       = 1'b0;
    fire_id         = CMD_NONE;
    if (code_valid) begin
      if (is_break) begin
        // Only the release of the held key clears it.
        if (repeat_hit) held_valid_next = 1'b0;
      end else begin
        held_valid_next = 1'b1;
        held_key_next   = key;
        // Typematic repeats are dropped except for arrows (auto-move).
        if (!repeat_hit || is_arrow) begin
          case (entry_reg)
            E_IDLE: begin
              if (is_ext) begin
                case (code)
                  SC_UP:    begin fire = 1'b1; fire_id = CMD_UP;    end
                  SC_DOWN:  begin fire = 1'b1; fire_id = CMD_DOWN;  end
                  SC_LEFT:  begin fire = 1'b1; fire_id = CMD_LEFT;  end
                  SC_RIGHT: begin fire = 1'b1; fire_id = CMD_RIGHT; end
                  SC_ENTER: begin fire = 1'b1; fire_id = CMD_ENTER; end
                  default:  ;
                endcase
              end else begin
                case (code)
                  SC_ENTER: begin fire = 1'b1; fire_id = CMD_ENTER;       end
                  SC_C:     begin fire = 1'b1; fire_id = CMD_COLOR;       end
                  SC_SPACE: begin fire = 1'b1; fire_id = CMD_PALETTE_SEL; end
                  SC_ESC:   begin fire = 1'b1; fire_id = CMD_RETURN_DRAW; end
                  SC_P:     entry_next = E_X;
                  default:  ;
                endcase
              end
            end
            E_X: begin
              if (esc_key) begin
                entry_next = E_IDLE;
              end else if (hex_ok) begin
                x_hold_next = hex_res[3:0];
                entry_next  = E_Y;
              end
            end
            E_Y: begin
              if (esc_key) begin
                entry_next = E_IDLE;
              end else if (hex_ok) begin
                fire       = 1'b1;
                fire_move  = 1'b1;
                fire_id    = CMD_PALETTE_MOVE;
                entry_next = E_IDLE;
              end
            end
            default: entry_next = E_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid_reg <= 1'b0;
      held_key_reg   <= '0;
      entry_reg      <= E_IDLE;
      x_hold_reg     <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_id_reg     <= CMD_NONE;
      x_reg          <= '0;
      y_reg          <= '0;
    end else begin
      held_valid_reg <= held_valid_next;
      held_key_reg   <= held_key_next;
      entry_reg      <= entry_next;
      x_hold_reg     <= x_hold_next;
      cmd_valid_reg  <= fire;
      if (fire) cmd_id_reg <= fire_id;
      if (fire_move) begin
        x_reg <= {3'b000, x_hold_reg};
        y_reg <= {3'b000, hex_res[3:0]};
      end
    end
  end

  assign bus.cmd_valid    = cmd_valid_reg;
  assign bus.cmd_id       = cmd_id_reg;
  assign bus.x_in         = x_reg;
  assign bus.y_in         = y_reg;
  assign bus.entry_active = (entry_reg != E_IDLE);

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: directed test-plan sequences followed by
// random byte streams, compared against a byte-level reference model.
module tb_key_cmd_decoder;

  localparam int PT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  key_cmd_decoder_if bus();

  key_cmd_decoder #(.PREFIX_TIMEOUT(PT), .TO_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (byte-level view of the keyboard protocol)
  bit m_ext, m_brk;
  int m_held;       // {ext,code} of held key, -1 when none
  int m_mode;       // 0 normal, 1 waiting x digit, 2 waiting y digit
  int m_x;
  int m_gap;
  bit e_valid;
  int e_id, e_x, e_y;

  logic [7:0] hex_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  function automatic int hex_of(input logic [7:0] b);
    for (int i = 0; i < 16; i++)
      if (hex_tab[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = -1; m_mode = 0; m_x = 0; m_gap = 0;
    e_valid = 0; e_id = 0; e_x = 0; e_y = 0;
  endtask

  task automatic emit(input int id);
    e_valid = 1;
    e_id = id;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ext, brk, arrow;
    int k, h;
    if (!m_brk && b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0 && !(m_brk && m_ext)) begin m_brk = 1; return; end
    ext = m_ext; brk = m_brk; m_ext = 0; m_brk = 0;
    k = (ext ? 256 : 0) + int'(b);
    if (brk) begin
      if (m_held == k) m_held = -1;
      return;
    end
    arrow = ext && (b == 8'h75 || b == 8'h72 || b == 8'h6B || b == 8'h74);
    if (m_held == k && !arrow) return;
    m_held = k;
    h = ext ? -1 : hex_of(b);
    if (m_mode == 0) begin
      if (ext) begin
        if (b == 8'h75) emit(1);
        else if (b == 8'h72) emit(2);
        else if (b == 8'h6B) emit(3);
        else if (b == 8'h74) emit(4);
        else if (b == 8'h5A) emit(5);
      end else begin
        if (b == 8'h5A) emit(5);
        else if (b == 8'h21) emit(6);
        else if (b == 8'h29) emit(8);
        else if (b == 8'h76) emit(9);
        else if (b == 8'h4D) m_mode = 1;
      end
    end else if (!ext && b == 8'h76) begin
      m_mode = 0;
    end else if (h >= 0) begin
      if (m_mode == 1) begin
        m_x = h;
        m_mode = 2;
      end else begin
        emit(7);
        e_x = m_x;
        e_y = h;
        m_mode = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("cmd_valid", {31'd0, bus.cmd_valid}, {31'd0, e_valid});
    check_eq("entry_active", {31'd0, bus.entry_active}, (m_mode != 0) ? 32'd1 : 32'd0);
    check_eq("cmd_id", {28'd0, bus.cmd_id}, e_id);
    check_eq("x_in", {25'd0, bus.x_in}, e_x);
    check_eq("y_in", {25'd0, bus.y_in}, e_y);
  endtask

  // One clock: check outputs caused by the previous cycle, then drive this one.
  task automatic cycle(input bit v, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    bus.scan_valid = v;
    bus.scan_code  = v ? b : 8'h00;
    e_valid = 0;
    if (v) begin
      m_gap = 0;
      model_byte(b);
    end else if (m_ext || m_brk) begin
      m_gap++;
      if (m_gap > PT) begin m_ext = 0; m_brk = 0; end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    cycle(1'b1, b);
    for (int i = 0; i < gap; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    reset = 1'b0;
    model_reset();
    #1 check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  logic [7:0] rb;
  int sel, gap;

  initial begin
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    #3 do_reset();

    // E0 75 -> UP; E0 F0 75 -> nothing, held cleared
    send(8'hE0, 0); send(8'h75, 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 1);
    // ENTER typematic filtering
    send(8'h5A, 0); send(8'h5A, 0); send(8'h5A, 0);
    send(8'hF0, 0); send(8'h5A, 0); send(8'h5A, 1);
    // RIGHT repeats pass
    for (int i = 0; i < 3; i++) begin send(8'hE0, 0); send(8'h74, 0); end
    cycle(1'b0, 8'h00);
    // palette entry F,2
    send(8'h4D, 1); send(8'h2B, 1); send(8'h1E, 2);
    // entry abort, then COLOR
    send(8'h4D, 0); send(8'h21, 0); send(8'h76, 1); send(8'h21, 2);
    // prefix timeout
    send(8'hE0, PT + 4); send(8'h75, 1);
    send(8'hE0, 0); send(8'h75, 2);
    // reset mid-sequence
    send(8'hE0, 0); send(8'hF0, 0);
    @(posedge clk);
    #2 do_reset();
    send(8'h74, 1);
    send(8'hE0, 0); send(8'h74, 2);

    // randomized streams
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 19);
      case (sel)
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = 8'h75;
        3: rb = 8'h72;
        4: rb = 8'h6B;
        5: rb = 8'h74;
        6: rb = 8'h5A;
        7: rb = 8'h21;
        8: rb = 8'h29;
        9: rb = 8'h76;
        10: rb = 8'h4D;
        11, 12, 13, 14, 15, 16: rb = hex_tab[$urandom_range(0, 15)];
        default: rb = 8'($urandom_range(0, 255));
      endcase
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 40) == 0) gap = PT + 3;
      send(rb, gap);
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
